// File: rtl/decode_stage.sv
// Single registered MIPS decode stage with ready/valid handshake,
// load-use bubble insertion and flush.
module decode_stage #(
    parameter int unsigned ALUC_W    = 6,
    parameter bit          EN_BNE    = 1'b1,
    parameter bit          EN_SHIFTV = 1'b1,
    parameter bit          HAZARD_EN = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ALUC_W-1:0] alu_op,
    output logic [4:0]        shamt,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       imm,
    output logic              rf_we,
    output logic              dm_rd,
    output logic              dm_wr,
    output logic              use_imm,
    output logic              shift_var,
    output logic              is_branch,
    output logic              br_ne,
    output logic              is_jump,
    output logic              illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [3:0] {
        ALU_ADDU = 4'd0,  ALU_SUBU = 4'd1,  ALU_ADD  = 4'd2,  ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,  ALU_NOR  = 4'd5,  ALU_XOR  = 4'd6,  ALU_SUB  = 4'd7,
        ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_SLT  = 4'd11,
        ALU_SLTU = 4'd12, ALU_MOVN = 4'd13, ALU_MOVZ = 4'd14, ALU_LUI  = 4'd15
    } alu_code_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ   = 6'h04, OP_BNE  = 6'h05,
        OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F,
        OP_LW    = 6'h23, OP_SW    = 6'h2B
    } opcode_t;

    logic [5:0]  op, fn;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [31:0] sext, zext;
    alu_code_t   d_alu;
    logic [4:0]  d_waddr;
    logic [31:0] d_imm;
    logic        d_we, d_rd, d_wr, d_uimm, d_svar, d_br, d_bne, d_jmp, d_ill;
    logic        reads_rt, hazard, in_fire, out_fire;

    assign op    = inst[31:26];
    assign fn    = inst[5:0];
    assign in_rs = inst[25:21];
    assign in_rt = inst[20:16];
    assign in_rd = inst[15:11];
    assign sext  = {{16{inst[15]}}, inst[15:0]};
    assign zext  = {16'h0000, inst[15:0]};

    always_comb begin
        d_alu   = ALU_ADDU;
        d_waddr = '0;
        d_imm   = '0;
        d_we    = 1'b0;
        d_rd    = 1'b0;
        d_wr    = 1'b0;
        d_uimm  = 1'b0;
        d_svar  = 1'b0;
        d_br    = 1'b0;
        d_bne   = 1'b0;
        d_jmp   = 1'b0;
        d_ill   = 1'b0;
        case (op)
            OP_RTYPE: begin
                d_we    = (inst != '0);
                d_waddr = in_rd;
                case (fn)
                    6'h00: d_alu = (inst == '0) ? ALU_ADDU : ALU_SLL;
                    6'h02: d_alu = ALU_SRL;
                    6'h03: d_alu = ALU_SRA;
                    6'h04: begin d_alu = ALU_SLL; d_svar = 1'b1; d_ill = !EN_SHIFTV; end
                    6'h06: begin d_alu = ALU_SRL; d_svar = 1'b1; d_ill = !EN_SHIFTV; end
                    6'h07: begin d_alu = ALU_SRA; d_svar = 1'b1; d_ill = !EN_SHIFTV; end
                    6'h0A: d_alu = ALU_MOVZ;
                    6'h0B: d_alu = ALU_MOVN;
                    6'h20: d_alu = ALU_ADD;
                    6'h21: d_alu = ALU_ADDU;
                    6'h22: d_alu = ALU_SUB;
                    6'h23: d_alu = ALU_SUBU;
                    6'h24: d_alu = ALU_AND;
                    6'h25: d_alu = ALU_OR;
                    6'h26: d_alu = ALU_XOR;
                    6'h27: d_alu = ALU_NOR;
                    6'h2A: d_alu = ALU_SLT;
                    6'h2B: d_alu = ALU_SLTU;
                    default: d_ill = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                d_we    = 1'b1;
                d_waddr = in_rt;
                d_uimm  = 1'b1;
                d_imm   = sext;
                case (op)
                    OP_ADDI:  d_alu = ALU_ADD;
                    OP_SLTI:  d_alu = ALU_SLT;
                    OP_SLTIU: d_alu = ALU_SLTU;
                    OP_ANDI:  begin d_alu = ALU_AND; d_imm = zext; end
                    OP_ORI:   begin d_alu = ALU_OR;  d_imm = zext; end
                    OP_XORI:  begin d_alu = ALU_XOR; d_imm = zext; end
                    OP_LUI:   begin d_alu = ALU_LUI; d_imm = {inst[15:0], 16'h0000}; end
                    default:  d_alu = ALU_ADDU;
                endcase
            end
            OP_LW: begin d_we = 1'b1; d_waddr = in_rt; d_rd = 1'b1; d_uimm = 1'b1; d_imm = sext; end
            OP_SW: begin d_wr = 1'b1; d_uimm = 1'b1; d_imm = sext; end
            OP_BEQ: begin d_alu = ALU_SUBU; d_br = 1'b1; d_imm = sext; end
            OP_BNE: begin
                d_alu = ALU_SUBU; d_br = 1'b1; d_bne = 1'b1; d_imm = sext; d_ill = !EN_BNE;
            end
            OP_J:    d_jmp = 1'b1;
            default: d_ill = 1'b1;
        endcase
        // An illegal decode carries no side effects, whatever the case arms set.
        if (d_ill) begin
            d_alu   = ALU_ADDU;
            d_waddr = '0;
            d_imm   = '0;
            d_we    = 1'b0;
            d_rd    = 1'b0;
            d_wr    = 1'b0;
            d_uimm  = 1'b0;
            d_svar  = 1'b0;
            d_br    = 1'b0;
            d_bne   = 1'b0;
            d_jmp   = 1'b0;
        end
    end

    assign reads_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    assign hazard   = HAZARD_EN && out_valid && dm_rd && (rf_waddr != '0) && in_valid &&
                      ((in_rs == rf_waddr) || (reads_rt && (in_rt == rf_waddr)));
    assign in_ready = !rst && (!out_valid || out_ready) && !hazard && !flush;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_op    <= '0;
            shamt     <= '0;
            rs        <= '0;
            rt        <= '0;
            rf_waddr  <= '0;
            imm       <= '0;
            rf_we     <= 1'b0;
            dm_rd     <= 1'b0;
            dm_wr     <= 1'b0;
            use_imm   <= 1'b0;
            shift_var <= 1'b0;
            is_branch <= 1'b0;
            br_ne     <= 1'b0;
            is_jump   <= 1'b0;
            illegal   <= 1'b0;
            stall_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            alu_op    <= ALUC_W'(d_alu);
            shamt     <= inst[10:6];
            rs        <= in_rs;
            rt        <= in_rt;
            rf_waddr  <= d_waddr;
            imm       <= d_imm;
            rf_we     <= d_we;
            dm_rd     <= d_rd;
            dm_wr     <= d_wr;
            use_imm   <= d_uimm;
            shift_var <= d_svar;
            is_branch <= d_br;
            br_ne     <= d_bne;
            is_jump   <= d_jmp;
            illegal   <= d_ill;
        end else if (out_fire) begin
            out_valid <= 1'b0;
            if (hazard && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters SHALL be one per line: ALUC_W, 6, ALU-op width (min 4, upper bits zero); EN_BNE, 1, decode bne; EN_SHIFTV, 1, decode sllv/srlv/srav; HAZARD_EN, 1, load-use bubble insertion; CNT_W, 16, stall counter width.
REQ-002 Ports SHALL be one per line:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  inst valid
in_ready  out  1  stage accepts inst
inst  in  32  MIPS instruction
flush  in  1  kill held and incoming inst
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
alu_op  out  ALUC_W  ALU operation code
shamt  out  5  inst[10:6]
rs, rt, rf_waddr  out  5 each  source/dest register numbers
imm  out  32  extended immediate
rf_we, dm_rd, dm_wr, use_imm, shift_var, is_branch, br_ne, is_jump, illegal  out  1 each  control flags
stall_cnt  out  CNT_W  bubbles inserted, saturating

Function
REQ-003 The block SHALL be a single registered decode stage; all outputs except in_ready SHALL come from flops.
REQ-004 Ready/valid handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-005 in_ready SHALL equal (~out_valid | out_ready) & ~hazard & ~flush.
REQ-006 On in_fire the register SHALL load the decoded bundle and set out_valid=1 next cycle; latency exactly 1 cycle.
REQ-007 On out_fire without in_fire, out_valid SHALL clear; with out_valid=1 & ~out_ready, bundle SHALL hold unchanged.
REQ-008 alu_op codes: ADDU 0 (addu, addiu, lw, sw, j), SUBU 1 (subu, beq, bne), ADD 2 (add, addi), AND 3 (and, andi), OR 4 (or, ori), NOR 5, XOR 6 (xor, xori), SUB 7, SLL 8 (sll, sllv), SRL 9 (srl, srlv), SRA 10 (sra, srav), SLT 11 (slt, slti), SLTU 12 (sltu, sltiu), MOVN 13, MOVZ 14, LUI 15.
REQ-009 rf_waddr SHALL be rd for R-type, rt for I-type writers, 0 otherwise; rf_we=1 for all ALU/lw/lui writers, 0 for sw, beq, bne, j, nop (inst=0), illegal.
REQ-010 imm: sign-extended inst[15:0] for addi, addiu, slti, sltiu, lw, sw, beq, bne; zero-extended for andi, ori, xori; {inst[15:0],16'h0} for lui; 0 otherwise.
REQ-011 use_imm=1 for all I-type ALU ops, lw, sw; dm_rd=lw; dm_wr=sw; is_branch=beq|bne; br_ne=bne; is_jump=j (op 000010); shift_var=1 for sllv/srlv/srav.
REQ-012 Any opcode/funct outside REQ-008 (including bne when EN_BNE=0, variable shifts when EN_SHIFTV=0) SHALL set illegal=1 with rf_we, dm_rd, dm_wr, is_branch, is_jump all 0.
REQ-013 hazard (HAZARD_EN=1) SHALL be out_valid & dm_rd & rf_waddr!=0 & in_valid & (inst.rs==rf_waddr | (inst reads rt & inst.rt==rf_waddr)); "reads rt" = R-type, sw, beq, bne. HAZARD_EN=0 forces hazard=0.
REQ-014 During hazard, out_fire SHALL leave out_valid=0 (one bubble); held inst SHALL be accepted the following cycle.
REQ-015 stall_cnt SHALL increment once per inserted bubble (hazard & out_fire), saturating at all-ones.
REQ-016 flush SHALL clear out_valid next cycle and drop inst regardless of hazard or out_ready; flush beats simultaneous in_valid and hazard; stall_cnt not incremented.
REQ-017 inst=0 SHALL decode as legal nop: out_valid=1, every control flag 0.

Reset
REQ-018 While rst=1: out_valid=0, stall_cnt=0, all bundle outputs 0; in_ready=0 during reset, follows REQ-005 after release.
REQ-019 rst asserted mid-hazard or mid-backpressure SHALL discard held state immediately, independent of clk.

Verification
REQ-020 add r1,r2,r3 (0x00430820), out_ready=1 -> next cycle out_valid=1, alu_op=2, rs=2, rt=3, rf_waddr=1, rf_we=1, use_imm=0.
REQ-021 lw r8,0(r9) (0x8D280000) then addu r10,r8,r11 (0x010B5021) -> lw out, one cycle out_valid=0, addu out next; stall_cnt=1.
REQ-022 Same sequence with HAZARD_EN=0 -> no bubble, stall_cnt=0.
REQ-023 out_ready=0 for 3 cycles with valid bundle -> bundle stable, in_ready=0; release -> single transfer, no duplicate.
REQ-024 flush during REQ-021 hazard -> out_valid=0 next cycle, held addu dropped, stall_cnt=0.
REQ-025 inst=0xFC000000 -> illegal=1, rf_we=0, dm_wr=0; inst=0x00000000 -> illegal=0, all flags 0.
